button_debouncer: RTL and testbench

- Conditions one raw mechanical push-button input and drives the `button` input of the ALU mode-select stage.
- Provides a debounced level, single-cycle press and release pulses, and optional auto-repeat pulses while the button is held.
- Sits directly between the board pin and the mode-select cycling logic.
- Single clock domain, so all outputs are glitch-free and registered.

---
 rtl/button_debouncer.sv | 181 ++++++++++++++++++
 tb/tb_button_debouncer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Push-button conditioner feeding the ALU mode-select stage.
// The raw pin is polarity-corrected and passed through a two-flop synchronizer.
// A five-state FSM then turns it into:
//   - a debounced level,
//   - one-cycle press and release pulses,
//   - optional auto-repeat (hold) pulses while the button stays down.
// step_pulse is the single strobe the mode-select logic advances on.
// Every output comes straight from a flop.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 12500000,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter bit          ACTIVE_LOW      = 1'b0,
    parameter int unsigned CNT_W           = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse,
    output logic step_pulse
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        REPEAT,
        RELEASE_WAIT
    } state_e;

    // Terminal counts, one per counting state.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             btn_level_q, btn_level_d;
    logic             press_q,     press_d;
    logic             release_q,   release_d;
    logic             hold_q,      hold_d;
    logic             step_q,      step_d;

    logic             raw_s;
    logic [CNT_W-1:0] cnt_inc;

    // After polarity correction, 1 always means "pressed".
    // The FSM only ever looks at the second synchronizer stage.
    assign raw_s   = sync2_q;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state, counter and pulse logic for the debounce / hold FSM.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        sync1_d     = button_raw ^ ACTIVE_LOW;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        btn_level_d = btn_level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        hold_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (raw_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end

            PRESS_WAIT: begin
                if (!raw_s) begin
                    // A bounce: drop back quietly.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = PRESSED;
                    cnt_d       = '0;
                    btn_level_d = 1'b1;
                    press_d     = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            PRESSED: begin
                if (!raw_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    // With repeat disabled the counter parks here.
                    // It never wraps in that case.
                    if (REPEAT_EN) begin
                        state_d = REPEAT;
                        cnt_d   = '0;
                        hold_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            REPEAT: begin
                if (!raw_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d  = '0;
                    hold_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            RELEASE_WAIT: begin
                if (raw_s) begin
                    // A glitch during release.
                    // Resume as a fresh hold with no pulse.
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    btn_level_d = 1'b0;
                    release_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                btn_level_d = 1'b0;
            end
        endcase

        step_d = press_d | hold_d;
    end

    // State, counter, synchronizer and registered outputs.
    // A reset lands everything in IDLE at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            btn_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            hold_q      <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge values together.
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_level_q <= btn_level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            hold_q      <= hold_d;
            step_q      <= step_d;
        end
    end

    assign btn_level     = btn_level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign hold_pulse    = hold_q;
    assign step_pulse    = step_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer.
// Stimulus pushes each expected pulse event (edge index plus pulse vector) into a queue.
// A monitor per DUT pops and compares whenever a pulse appears.
// Instance dut uses the standard parameters.
// Instance dut_al is the active-low variant with repeat disabled.
module tb_button_debouncer;

    typedef struct {
        int         cyc;
        logic [3:0] vec;   // {press, release, hold, step}
    } exp_t;

    localparam logic [3:0] V_PRESS = 4'b1001;
    localparam logic [3:0] V_REL   = 4'b0100;
    localparam logic [3:0] V_HOLD  = 4'b0011;

    logic clk;
    logic rst_n;
    logic raw;
    logic raw_al;
    logic lvl,    prs,    rel,    hld,    stp;
    logic lvl_al, prs_al, rel_al, hld_al, stp_al;

    int   cyc;
    int   n_checks;
    int   n_pass;
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    exp_t e0, e1;
    logic [3:0] v0, v1;

    button_debouncer #(
        .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(5),
        .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b0), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .button_raw(raw),
        .btn_level(lvl), .press_pulse(prs), .release_pulse(rel),
        .hold_pulse(hld), .step_pulse(stp)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(5),
        .REPEAT_EN(1'b0), .ACTIVE_LOW(1'b1), .CNT_W(8)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .button_raw(raw_al),
        .btn_level(lvl_al), .press_pulse(prs_al), .release_pulse(rel_al),
        .hold_pulse(hld_al), .step_pulse(stp_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index: after posedge number n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push0(input int c, input logic [3:0] v);
        exp_q0.push_back('{cyc: c, vec: v});
    endtask

    task automatic push1(input int c, input logic [3:0] v);
        exp_q1.push_back('{cyc: c, vec: v});
    endtask

    // Call only at a negedge; returns at the negedge where cyc == t.
    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor for dut. Any pulse is checked against the queue head.
    // A head whose edge has passed with no pulse counts as a miss.
    always @(negedge clk) begin
        v0 = {prs, rel, hld, stp};
        if (v0 != 4'b0000) begin
            if (exp_q0.size() == 0) begin
                check("dut_unexpected_pulse", 32'(v0), 32'h0);
            end else begin
                e0 = exp_q0.pop_front();
                check("dut_pulse_cycle", cyc, e0.cyc);
                check("dut_pulse_vector", 32'(v0), 32'(e0.vec));
            end
        end else if (exp_q0.size() != 0 && exp_q0[0].cyc <= cyc) begin
            e0 = exp_q0.pop_front();
            check("dut_missed_pulse", 32'(v0), 32'(e0.vec));
        end
    end

    // Monitor for dut_al.
    always @(negedge clk) begin
        v1 = {prs_al, rel_al, hld_al, stp_al};
        if (v1 != 4'b0000) begin
            if (exp_q1.size() == 0) begin
                check("al_unexpected_pulse", 32'(v1), 32'h0);
            end else begin
                e1 = exp_q1.pop_front();
                check("al_pulse_cycle", cyc, e1.cyc);
                check("al_pulse_vector", 32'(v1), 32'(e1.vec));
            end
        end else if (exp_q1.size() != 0 && exp_q1[0].cyc <= cyc) begin
            e1 = exp_q1.pop_front();
            check("al_missed_pulse", 32'(v1), 32'(e1.vec));
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p;
        int m;
        cyc      = 0;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        raw      = 1'b0;
        raw_al   = 1'b1;   // active-low pin idles high

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_btn_level",  32'(lvl), 0);
        check("rst_press",      32'(prs), 0);
        check("rst_release",    32'(rel), 0);
        check("rst_hold",       32'(hld), 0);
        check("rst_step",       32'(stp), 0);
        check("rst_al_level",   32'(lvl_al), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press, then auto-repeat at P+10, P+15, P+20, P+25.
        // After that, a one-sample glitch while in REPEAT restarts the hold: next hold at P+40.
        p   = cyc + 7;
        raw = 1'b1;
        push0(p, V_PRESS);
        push0(p + 10, V_HOLD);
        push0(p + 15, V_HOLD);
        push0(p + 20, V_HOLD);
        push0(p + 25, V_HOLD);
        push0(p + 40, V_HOLD);
        wait_cyc(p - 1);
        check("press_level_before", 32'(lvl), 0);
        wait_cyc(p);
        check("press_level_after", 32'(lvl), 1);
        wait_cyc(p + 26);
        raw = 1'b0;
        wait_cyc(p + 27);
        raw = 1'b1;
        wait_cyc(p + 30);
        check("repeat_glitch_level", 32'(lvl), 1);

        // Asynchronous reset mid-cycle while in REPEAT
        wait_cyc(p + 42);
        #2;
        rst_n = 1'b0;
        raw   = 1'b0;
        #1;
        check("midrst_btn_level", 32'(lvl), 0);
        check("midrst_press",     32'(prs), 0);
        check("midrst_release",   32'(rel), 0);
        check("midrst_hold",      32'(hld), 0);
        check("midrst_step",      32'(stp), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("postrst_level", 32'(lvl), 0);
        check("seq_a_queue_drained", 32'(exp_q0.size()), 0);

        // Bounce rejection: runs of three highs, never long enough to accept
        for (int i = 0; i < 40; i++) begin
            raw = ((i % 4) != 3);
            @(negedge clk);
            check("bounce_level", 32'(lvl), 0);
        end
        raw = 1'b0;
        repeat (4) @(negedge clk);

        // Release glitch: low 2, high 1, then low.
        // The glitch sample takes the FSM back to PRESSED.
        // The final low enters RELEASE_WAIT at m+6; the release pulse follows at m+10.
        p   = cyc + 7;
        raw = 1'b1;
        push0(p, V_PRESS);
        m = p + 2;
        push0(m + 10, V_REL);
        wait_cyc(m);
        raw = 1'b0;
        wait_cyc(m + 2);
        raw = 1'b1;
        wait_cyc(m + 3);
        raw = 1'b0;
        for (int c = m; c <= m + 9; c++) begin
            wait_cyc(c);
            check("release_glitch_level", 32'(lvl), 1);
        end
        wait_cyc(m + 14);
        check("release_level_final", 32'(lvl), 0);
        check("seq_c_queue_drained", 32'(exp_q0.size()), 0);

        // Active-low pin, repeat disabled: idle 30 cycles, then held 30 cycles.
        repeat (30) @(negedge clk);
        check("al_idle_level", 32'(lvl_al), 0);
        p      = cyc + 7;
        raw_al = 1'b0;
        push1(p, V_PRESS);
        repeat (30) @(negedge clk);
        check("al_held_level", 32'(lvl_al), 1);
        check("al_queue_drained", 32'(exp_q1.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
